// File: rtl/if_id_queue.sv
// IF/ID boundary: DEPTH-entry instruction queue feeding a registered decode-side
// output stage, with jump/interrupt flush and NOP bubble insertion when empty.
module if_id_queue #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0]   NOP_INST   = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         inst_valid_i,
  input  logic [ADDR_WIDTH-1:0]        inst_addr_i,
  input  logic [DATA_WIDTH-1:0]        inst_i,
  output logic                         ready_o,
  input  logic                         id_stall_i,
  input  logic                         flush_jump_i,
  input  logic                         flush_interrupt_i,
  output logic [ADDR_WIDTH-1:0]        inst_addr_o,
  output logic [DATA_WIDTH-1:0]        inst_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_inst [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_inst;
  logic                  r_out_valid;

  logic w_flush;
  logic w_push;
  logic w_adv;
  logic w_empty;
  logic w_bypass;
  logic w_wr;
  logic w_pop;

  // ready_o is a pure function of registered occupancy.
  assign ready_o  = (r_count != CW'(DEPTH));
  assign w_flush  = flush_jump_i | flush_interrupt_i;
  assign w_push   = inst_valid_i & ready_o;
  assign w_adv    = ~id_stall_i;
  assign w_empty  = (r_count == '0);

  // An empty queue with decode advancing sends the fetched word straight out.
  assign w_bypass = w_adv & w_empty & w_push;
  assign w_wr     = w_push & ~w_flush & ~w_bypass;
  assign w_pop    = w_adv & ~w_flush & ~w_empty;

  always_ff @(posedge clk_i) begin
    if (w_wr && !rst_i) begin
      r_mem_addr[r_wr_ptr] <= inst_addr_i;
      r_mem_inst[r_wr_ptr] <= inst_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_flush) begin
      r_out_addr  <= '0;
      r_out_inst  <= NOP_INST;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      if (!w_empty) begin
        r_out_addr  <= r_mem_addr[r_rd_ptr];
        r_out_inst  <= r_mem_inst[r_rd_ptr];
        r_out_valid <= 1'b1;
      end else if (w_push) begin
        r_out_addr  <= inst_addr_i;
        r_out_inst  <= inst_i;
        r_out_valid <= 1'b1;
      end else begin
        r_out_addr  <= '0;
        r_out_inst  <= NOP_INST;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign inst_addr_o = r_out_addr;
  assign inst_o      = r_out_inst;
  assign valid_o     = r_out_valid;
  assign count_o     = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue: bypass, stall/fill/drain,
// flushes, steady push/pop across pointer wrap, and mid-operation reset.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        inst_valid_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic [31:0] inst_i = '0;
  logic        ready_o;
  logic        id_stall_i = 1'b0;
  logic        flush_jump_i = 1'b0;
  logic        flush_interrupt_i = 1'b0;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic [2:0]  count_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  if_id_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .NOP_INST(32'h0000_0013)) dut (
    .clk_i(clk), .rst_i(rst_i), .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .inst_i(inst_i), .ready_o(ready_o), .id_stall_i(id_stall_i),
    .flush_jump_i(flush_jump_i), .flush_interrupt_i(flush_interrupt_i),
    .inst_addr_o(inst_addr_o), .inst_o(inst_o), .valid_o(valid_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hAB00_0000 | a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a);
    inst_valid_i = v;
    inst_addr_i  = a;
    inst_i       = word_of(a);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++;
    if ({valid_o, inst_addr_o, inst_o, count_o, ready_o} !== {1'b0, 32'h0, NOP, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset: got v=%0b a=%h i=%h c=%0d r=%0b want v=0 a=0 i=%h c=0 r=1",
               valid_o, inst_addr_o, inst_o, count_o, ready_o, NOP);
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(4 * i);
      drive(1'b1, a);
      tick();
      total++;
      if ({valid_o, inst_addr_o, inst_o, count_o} !== {1'b1, a, word_of(a), 3'd0}) begin
        bad++;
        $display("FAIL bypass[%0d]: got v=%0b a=%h i=%h c=%0d want v=1 a=%h i=%h c=0",
                 i, valid_o, inst_addr_o, inst_o, count_o, a, word_of(a));
      end
    end
    drive(1'b0, 32'h0);
    tick();
    total++;
    if ({valid_o, inst_addr_o, inst_o} !== {1'b0, 32'h0, NOP}) begin
      bad++;
      $display("FAIL bubble: got v=%0b a=%h i=%h want v=0 a=0 i=%h",
               valid_o, inst_addr_o, inst_o, NOP);
    end
  endtask

  task automatic test_stall_fill_drain();
    int k;
    logic [2:0] exp_cnt [6];
    logic       exp_rdy [6];
    exp_cnt = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    exp_rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    k = 0;
    id_stall_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 32'h200 + 32'(4 * k));
      total++;
      if (ready_o !== (c < 4)) begin
        bad++;
        $display("FAIL stall_ready[%0d]: got %0b want %0b", c, ready_o, (c < 4));
      end
      if (ready_o) k++;
      tick();
      total++;
      if ({count_o, valid_o, inst_addr_o} !== {3'((c < 4) ? c + 1 : 4), 1'b0, 32'h0}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got c=%0d v=%0b a=%h want c=%0d v=0 a=0",
                 c, count_o, valid_o, inst_addr_o, (c < 4) ? c + 1 : 4);
      end
    end
    id_stall_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      logic [31:0] ea;
      ea = 32'h200 + 32'(4 * c);
      if (k < 6) drive(1'b1, 32'h200 + 32'(4 * k));
      else       drive(1'b0, 32'h0);
      total++;
      if (ready_o !== exp_rdy[c]) begin
        bad++;
        $display("FAIL drain_ready[%0d]: got %0b want %0b", c, ready_o, exp_rdy[c]);
      end
      if (ready_o && inst_valid_i) k++;
      tick();
      total++;
      if ({valid_o, inst_addr_o, inst_o, count_o} !== {1'b1, ea, word_of(ea), exp_cnt[c]}) begin
        bad++;
        $display("FAIL drain[%0d]: got v=%0b a=%h i=%h c=%0d want v=1 a=%h i=%h c=%0d",
                 c, valid_o, inst_addr_o, inst_o, count_o, ea, word_of(ea), exp_cnt[c]);
      end
    end
    drive(1'b0, 32'h0);
    tick();
  endtask

  task automatic test_flush_jump();
    id_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i));
      tick();
    end
    total++;
    if (count_o !== 3'd3) begin
      bad++;
      $display("FAIL jump_pre_count: got %0d want 3", count_o);
    end
    id_stall_i   = 1'b0;
    flush_jump_i = 1'b1;
    drive(1'b1, 32'h30C);
    tick();
    flush_jump_i = 1'b0;
    drive(1'b0, 32'h0);
    total++;
    if ({valid_o, inst_addr_o, inst_o, count_o, ready_o} !== {1'b0, 32'h0, NOP, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL jump_flush: got v=%0b a=%h i=%h c=%0d r=%0b want v=0 a=0 i=%h c=0 r=1",
               valid_o, inst_addr_o, inst_o, count_o, ready_o, NOP);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({valid_o, inst_addr_o, count_o} !== {1'b0, 32'h0, 3'd0}) begin
        bad++;
        $display("FAIL jump_after[%0d]: got v=%0b a=%h c=%0d want v=0 a=0 c=0",
                 i, valid_o, inst_addr_o, count_o);
      end
    end
  endtask

  task automatic test_flush_interrupt();
    drive(1'b1, 32'h400);
    tick();
    id_stall_i = 1'b1;
    drive(1'b1, 32'h404);
    tick();
    total++;
    if ({valid_o, inst_addr_o, count_o} !== {1'b1, 32'h400, 3'd1}) begin
      bad++;
      $display("FAIL irq_pre: got v=%0b a=%h c=%0d want v=1 a=400 c=1",
               valid_o, inst_addr_o, count_o);
    end
    flush_interrupt_i = 1'b1;
    drive(1'b1, 32'h408);
    tick();
    flush_interrupt_i = 1'b0;
    drive(1'b0, 32'h0);
    total++;
    if ({valid_o, inst_addr_o, inst_o, count_o} !== {1'b0, 32'h0, NOP, 3'd0}) begin
      bad++;
      $display("FAIL irq_flush: got v=%0b a=%h i=%h c=%0d want v=0 a=0 i=%h c=0",
               valid_o, inst_addr_o, inst_o, count_o, NOP);
    end
    id_stall_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    id_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i));
      tick();
    end
    id_stall_i = 1'b0;
    for (int j = 0; j < 12; j++) begin
      logic [31:0] ea;
      ea = 32'h500 + 32'(4 * j);
      drive(1'b1, 32'h500 + 32'(4 * (j + 2)));
      tick();
      total++;
      if ({valid_o, inst_addr_o, inst_o, count_o} !== {1'b1, ea, word_of(ea), 3'd2}) begin
        bad++;
        $display("FAIL b2b[%0d]: got v=%0b a=%h i=%h c=%0d want v=1 a=%h i=%h c=2",
                 j, valid_o, inst_addr_o, inst_o, count_o, ea, word_of(ea));
      end
    end
    drive(1'b0, 32'h0);
    for (int j = 12; j < 14; j++) begin
      logic [31:0] ea;
      ea = 32'h500 + 32'(4 * j);
      tick();
      total++;
      if ({valid_o, inst_addr_o, count_o} !== {1'b1, ea, 3'(13 - j)}) begin
        bad++;
        $display("FAIL b2b_tail[%0d]: got v=%0b a=%h c=%0d want v=1 a=%h c=%0d",
                 j, valid_o, inst_addr_o, count_o, ea, 13 - j);
      end
    end
    tick();
  endtask

  task automatic test_reset_midop();
    id_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i));
      tick();
    end
    total++;
    if ({count_o, ready_o} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL full: got c=%0d r=%0b want c=4 r=0", count_o, ready_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(1'b0, 32'h0);
    total++;
    if ({valid_o, inst_addr_o, inst_o, count_o, ready_o} !== {1'b0, 32'h0, NOP, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL midop_reset: got v=%0b a=%h i=%h c=%0d r=%0b want v=0 a=0 i=%h c=0 r=1",
               valid_o, inst_addr_o, inst_o, count_o, ready_o, NOP);
    end
    id_stall_i = 1'b0;
    tick();
    total++;
    if ({valid_o, count_o} !== {1'b0, 3'd0}) begin
      bad++;
      $display("FAIL post_reset: got v=%0b c=%0d want v=0 c=0", valid_o, count_o);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_bypass();
    test_stall_fill_drain();
    test_flush_jump();
    test_flush_interrupt();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
